// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8:1 mux arbiter: sizes, FSM states and the
// round-robin search helper.
package mux_arb_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned DW    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1, ... ptr+7, modulo 8.
  function automatic pick_t rr_pick(input logic [N-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] k;
    p.found = 1'b0;
    p.idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = ptr + SEL_W'(i);
      if (!p.found && req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux8_dw.sv
// DW-wide 8:1 combinational data multiplexer.
module mux8_dw #(
  parameter int unsigned DW = mux_arb_pkg::DW
) (
  input  logic [8*DW-1:0] din,
  input  logic [2:0]      sel,
  output logic [DW-1:0]   out_data
);

  always_comb begin
    out_data = din[32'(sel)*DW +: DW];
  end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel among eight
// requesters; registered select drives the 8:1 data mux.
module rr_mux8_arbiter
  import mux_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*DW-1:0]    din,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [N-1:0]       grant,
  output logic [SEL_W-1:0]   sel,
  output logic [N-1:0]       ack,
  output logic               busy
);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] sel_n;
  logic [N-1:0]     grant_n;
  logic             hs;
  pick_t            pick_idle;
  pick_t            pick_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      grant <= grant_n;
    end
  end

  // The served requester drops to lowest priority by searching from sel+1.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    grant_n   = grant;
    hs        = (state == SERVE) && out_ready;
    pick_idle = rr_pick(req, ptr);
    pick_next = rr_pick(req, sel + SEL_W'(1));
    case (state)
      IDLE: begin
        if (pick_idle.found) begin
          sel_n   = pick_idle.idx;
          grant_n = N'(1) << pick_idle.idx;
          state_n = SERVE;
        end
      end
      SERVE: begin
        if (hs) begin
          ptr_n = sel + SEL_W'(1);
          if (pick_next.found) begin
            sel_n   = pick_next.idx;
            grant_n = N'(1) << pick_next.idx;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_comb begin
    out_valid = (state == SERVE);
    busy      = (state == SERVE);
    ack       = grant & {N{hs}};
  end

  mux8_dw #(.DW(DW)) u_mux (
    .din      (din),
    .sel      (sel),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed self-checking bench for rr_mux8_arbiter; inputs change and
// outputs are sampled around the falling edge.
module tb_rr_mux8_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [63:0] din;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [7:0]  grant;
  logic [2:0]  sel;
  logic [7:0]  ack;
  logic        busy;

  int unsigned errs   = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  rr_mux8_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .grant     (grant),
    .sel       (sel),
    .ack       (ack),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_din(input int i, input logic [7:0] v);
    din[i*8 +: 8] = v;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_din(i, 8'h10 + 8'(i));
    set_din(5, 8'hA5);

    // Reset held two cycles with all requests up
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_grant", 32'(grant), 32'h00);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ack", 32'(ack), 32'h00);
    end
    rst = 1'b0;
    #1;
    check("idle_no_valid", 32'(out_valid), 32'h0);
    step();
    check("first_grant", 32'(grant), 32'h01);
    check("first_sel", 32'(sel), 32'd0);
    check("first_valid", 32'(out_valid), 32'h1);
    check("first_data", 32'(out_data), 32'h10);

    // Fairness: all eight held, one transfer per cycle, 0..7,0
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("rr_sel_%0d", k), 32'(sel), 32'(k % 8));
      check($sformatf("rr_ack_%0d", k), 32'(ack), 32'(8'h01 << (k % 8)));
      if (k == 8) req = 8'h00;
      step();
    end
    check("rr_end_idle", 32'(out_valid), 32'h0);
    check("rr_end_grant", 32'(grant), 32'h00);

    // Single requester 5 (ptr now 1)
    req = 8'h20;
    #1;
    check("single_ack_idle", 32'(ack), 32'h00);
    step();
    check("single_sel", 32'(sel), 32'd5);
    check("single_grant", 32'(grant), 32'h20);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_ack", 32'(ack), 32'h20);
    req = 8'h00;
    #1;
    check("single_ack_hold", 32'(ack), 32'h20);
    step();
    check("single_idle_valid", 32'(out_valid), 32'h0);
    check("single_idle_ack", 32'(ack), 32'h00);
    check("single_idle_busy", 32'(busy), 32'h0);

    // ptr = 6, req 0 and 3: wrap to 0 first, then 3
    req = 8'h09;
    step();
    check("wrap_sel0", 32'(sel), 32'd0);
    check("wrap_ack0", 32'(ack), 32'h01);
    req = 8'h08;
    step();
    check("wrap_sel3", 32'(sel), 32'd3);
    check("wrap_ack3", 32'(ack), 32'h08);
    check("wrap_data3", 32'(out_data), 32'h13);
    req = 8'h00;
    step();
    check("wrap_idle", 32'(out_valid), 32'h0);

    // Backpressure on requester 2 (ptr = 4)
    out_ready = 1'b0;
    req       = 8'h04;
    step();
    for (int c = 0; c < 4; c++) begin
      if (c == 2) set_din(2, 8'h3C);
      #1;
      check($sformatf("bp_sel_%0d", c), 32'(sel), 32'd2);
      check($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'h1);
      check($sformatf("bp_ack_%0d", c), 32'(ack), 32'h00);
      check($sformatf("bp_data_%0d", c), 32'(out_data), (c >= 2) ? 32'h3C : 32'h12);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ack", 32'(ack), 32'h04);
    req = 8'h00;
    step();
    check("bp_idle", 32'(out_valid), 32'h0);

    // Reset while serving requester 4 with handshake pending (ptr = 3)
    out_ready = 1'b0;
    req       = 8'h10;
    step();
    check("mid_sel4", 32'(sel), 32'd4);
    check("mid_grant4", 32'(grant), 32'h10);
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    check("mid_rst_grant", 32'(grant), 32'h00);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_sel", 32'(sel), 32'd0);
    // ptr back at 0 means 4 beats 5; a post-handshake ptr of 5 would pick 5
    rst = 1'b0;
    req = 8'h30;
    step();
    check("mid_regrant_sel", 32'(sel), 32'd4);
    check("mid_regrant_grant", 32'(grant), 32'h10);
    check("mid_regrant_ack", 32'(ack), 32'h10);
    req = 8'h20;
    step();
    check("mid_next_sel", 32'(sel), 32'd5);
    check("mid_next_ack", 32'(ack), 32'h20);
    req = 8'h00;
    step();
    check("final_idle", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux8_arbiter.md
# rr_mux8_arbiter

Round-robin arbiter that shares one 8:1 multiplexed output channel among eight requesters. It holds a registered 3-bit select that drives an internal 8:1 data multiplexer. It presents the selected word on a valid/ready output port and pulses a per-requester acknowledge on each completed transfer. It sits between the requesting sources and a single downstream consumer, and serves as the sequencer for the team's 8:1 mux datapath.

## Interface
- `N`, 8, number of requesters; fixed at 8 for this revision.
- `SEL_W`, 3, select width, equal to log2(N).
- `DW`, 8, data width per requester.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N: per-requester request level.
- `din` input N*DW: packed data; requester i occupies `din[i*DW +: DW]`.
- `out_ready` input 1: downstream accepts the word this cycle.
- `out_valid` output 1: an output word is presented.
- `out_data` output DW: word of the granted requester.
- `grant` output N: one-hot grant, registered.
- `sel` output SEL_W: registered index of the granted requester.
- `ack` output N: one-cycle pulse on requester `sel` when a transfer completes.
- `busy` output 1: high while in state SERVE.

## Operation
- States:
  - IDLE: no grant.
  - SERVE: grant held, `out_valid` = 1.
- Pointer `ptr` (SEL_W bits) names the highest-priority requester.
  - Search order: `ptr`, `ptr+1`, … `ptr+7`, modulo 8.
- IDLE:
  - If `req` != 0, pick the first set bit in search order. Register `sel` and `grant` with that choice and go to SERVE.
  - Otherwise stay in IDLE.
- SERVE:
  - `out_data` = `din[sel]` combinationally through the mux; the data is not registered.
  - Handshake = `out_valid & out_ready`.
  - No handshake: hold `sel`, `grant` and the state.
  - On handshake:
    - `ack[sel]` = 1 in that same cycle; `ack` is combinational, `grant & {N{handshake}}`.
    - `ptr` ← `sel+1` (wraps 7→0).
    - Re-arbitrate immediately on the current `req` with the new pointer. The just-served requester is lowest priority.
    - If any request is found, load the new `sel`/`grant` and stay in SERVE (back-to-back transfers). Otherwise go to IDLE and clear `grant`.
- Requester protocol:
  - A requester keeps `req` and its data stable from request until it sees its `ack`.
  - `req` dropping while granted is ignored; the grant is held until handshake.
- `grant` is never multi-hot; `grant` == 0 if and only if state == IDLE.
- Reset values: state = IDLE, `ptr` = 0, `sel` = 0, `grant` = 0, `out_valid` = 0, `ack` = 0, `busy` = 0. `out_data` = `din[0]`, don't-care.

## Timing
- Grant latency: `req` first seen high in IDLE at edge t → `grant`/`out_valid` high after edge t, i.e. one cycle.
- Throughput: one transfer per cycle while requests are pending and `out_ready` = 1. Idle-to-first-transfer costs one extra cycle.
- Backpressure: `out_valid` stays high and `out_data` tracks `din[sel]` for any number of `out_ready` = 0 cycles.
- Simultaneous requests: resolved purely by `ptr`. With all eight held, grants cycle 0,1,…,7,0 with `out_ready` = 1.
- Wrap-around: `sel` = 7 served → `ptr` = 0.
- `rst` high in any cycle, including mid-SERVE with the handshake pending:
  - All state returns to reset values at that edge and no `ack` is issued.
  - A requester that was granted must re-arbitrate.
- `rst` and handshake in the same cycle: reset wins; `ack` is still combinationally high in that cycle. Verification treats it as a don't-care.

## Structure
- Shared package `mux_arb_pkg`:
  - `N`, `SEL_W`, `DW` defaults.
  - State enum {IDLE, SERVE}.
  - Function `rr_pick(req, ptr)` returning a found flag and an index.
- Sub-module `mux8_dw`: DW-wide 8:1 combinational mux, inputs `din` and `sel`, output `out_data`.
- The arbiter FSM, pointer and grant registers live in the top level.

## Test plan
- Reset: `rst` held 2 cycles with `req` = 8'hFF → `grant` = 0, `out_valid` = 0; first grant is to index 0 one cycle after `rst` falls.
- Single requester: `req` = 8'h20, `din[5]` = 8'hA5, `out_ready` = 1 → `sel` = 5, `out_data` = 8'hA5, `ack` = 8'h20 for one cycle, then IDLE.
- Round-robin fairness: `req` = 8'hFF held, `out_ready` = 1 → `sel` sequence 0,1,2,…,7,0 with one transfer per cycle.
- Pointer skip and wrap: `ptr` = 6 after serving 5, `req` = 8'h09 → order 0 then 3.
- Backpressure: granted index 2, `out_ready` low for 4 cycles → `sel` = 2, `out_valid` = 1 and `ack` = 0 throughout; `ack` = 8'h04 on the cycle `out_ready` rises.
- Reset mid-operation: `rst` pulsed while in SERVE with `sel` = 4 → next cycle IDLE, `ptr` = 0, `grant` = 0.
